// File: rtl/nco_sweep_ctrl.sv
// Drives NCO freq/scale/phase through ramp-up, N dwell-held frequency steps and ramp-down.
// Latency: outputs registered, first update on the start edge; no backpressure, start is ignored while busy.
module nco_sweep_ctrl #(
    parameter int FREQ_WIDTH  = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int PHASE_WIDTH = 13,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FREQ_WIDTH-1:0]  cfg_f_start,
    input  logic [FREQ_WIDTH-1:0]  cfg_f_step,
    input  logic [CNT_WIDTH-1:0]   cfg_num_steps,
    input  logic [CNT_WIDTH-1:0]   cfg_dwell,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SCALE_WIDTH-1:0] cfg_scale_step,
    input  logic [PHASE_WIDTH-1:0] cfg_phase,
    output logic [FREQ_WIDTH-1:0]  freq_out,
    output logic [SCALE_WIDTH-1:0] scale_out,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [CNT_WIDTH-1:0]   step_idx,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {IDLE, RAMP_UP, SWEEP, RAMP_DOWN, DONE} state_t;

    // Counts are stored as "last index" so a zero count naturally behaves as one.
    typedef struct packed {
        logic [FREQ_WIDTH-1:0]  f_step;
        logic [CNT_WIDTH-1:0]   last_step;
        logic [CNT_WIDTH-1:0]   dwell_last;
        logic [SCALE_WIDTH-1:0] scale;
        logic [SCALE_WIDTH-1:0] scale_step;
    } shadow_t;

    state_t                 state;
    shadow_t                shadow;
    logic [CNT_WIDTH-1:0]   dwell_cnt;
    logic [SCALE_WIDTH:0]   ramp_sum;
    logic [SCALE_WIDTH-1:0] ramp_up_nxt;
    logic [SCALE_WIDTH-1:0] ramp_dn_nxt;

    always_comb begin
        ramp_sum    = {1'b0, scale_out} + {1'b0, shadow.scale_step};
        ramp_up_nxt = ramp_sum[SCALE_WIDTH-1:0];
        ramp_dn_nxt = scale_out - shadow.scale_step;
        if (shadow.scale_step == '0 || ramp_sum >= {1'b0, shadow.scale})
            ramp_up_nxt = shadow.scale;
        if (shadow.scale_step == '0 || scale_out <= shadow.scale_step)
            ramp_dn_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shadow    <= '0;
            dwell_cnt <= '0;
            freq_out  <= '0;
            scale_out <= '0;
            phase_out <= '0;
            step_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow.f_step     <= cfg_f_step;
                        shadow.last_step  <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - CNT_WIDTH'(1);
                        shadow.dwell_last <= (cfg_dwell == '0) ? '0 : cfg_dwell - CNT_WIDTH'(1);
                        shadow.scale      <= cfg_scale;
                        shadow.scale_step <= cfg_scale_step;
                        freq_out          <= cfg_f_start;
                        phase_out         <= cfg_phase;
                        scale_out         <= '0;
                        step_idx          <= '0;
                        dwell_cnt         <= '0;
                        busy              <= 1'b1;
                        state             <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (abort) begin
                        state <= RAMP_DOWN;
                    end else begin
                        scale_out <= ramp_up_nxt;
                        if (ramp_up_nxt == shadow.scale)
                            state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state <= RAMP_DOWN;
                    end else if (dwell_cnt == shadow.dwell_last) begin
                        dwell_cnt <= '0;
                        if (step_idx == shadow.last_step) begin
                            state <= RAMP_DOWN;
                        end else begin
                            freq_out <= freq_out + shadow.f_step;
                            step_idx <= step_idx + CNT_WIDTH'(1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_WIDTH'(1);
                    end
                end
                RAMP_DOWN: begin
                    scale_out <= ramp_dn_nxt;
                    if (ramp_dn_nxt == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with hand-computed expected outputs.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_f_start = '0;
    logic [31:0] cfg_f_step = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [15:0] cfg_dwell = '0;
    logic [15:0] cfg_scale = '0;
    logic [15:0] cfg_scale_step = '0;
    logic [12:0] cfg_phase = '0;
    logic [31:0] freq_out;
    logic [15:0] scale_out;
    logic [12:0] phase_out;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_total = 0;
    int done_total = 0;
    int b0;
    int d0;

    nco_sweep_ctrl #(
        .FREQ_WIDTH(32), .SCALE_WIDTH(16), .PHASE_WIDTH(13), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step),
        .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell),
        .cfg_scale(cfg_scale), .cfg_scale_step(cfg_scale_step),
        .cfg_phase(cfg_phase),
        .freq_out(freq_out), .scale_out(scale_out), .phase_out(phase_out),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cycle counters sample the value held during the cycle that ends at each edge.
    always @(posedge clk) begin
        if (busy) busy_total <= busy_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n,
                           input logic [15:0] d, input logic [15:0] sc, input logic [15:0] scs,
                           input logic [12:0] ph);
        cfg_f_start    = fs;
        cfg_f_step     = fst;
        cfg_num_steps  = n;
        cfg_dwell      = d;
        cfg_scale      = sc;
        cfg_scale_step = scs;
        cfg_phase      = ph;
    endtask

    task automatic run_nominal(input string tag);
        set_cfg(85899, 85899, 4, 3, 16384, 4096, 13'h0A5);
        b0 = busy_total;
        d0 = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".busy0"}, 64'(busy), 64'(1));
        check({tag, ".scale0"}, 64'(scale_out), 64'(0));
        check({tag, ".freq0"}, 64'(freq_out), 64'(85899));
        check({tag, ".phase"}, 64'(phase_out), 64'(13'h0A5));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check({tag, ".ramp_up"}, 64'(scale_out), 64'(4096 * k));
        end
        for (int j = 0; j < 12; j++) begin
            check({tag, ".sweep_freq"}, 64'(freq_out), 64'(85899 * (j / 3 + 1)));
            check({tag, ".sweep_idx"}, 64'(step_idx), 64'(j / 3));
            tick();
        end
        check({tag, ".rd_freq"}, 64'(freq_out), 64'(343596));
        check({tag, ".rd_scale0"}, 64'(scale_out), 64'(16384));
        for (int k = 3; k >= 0; k--) begin
            tick();
            check({tag, ".ramp_down"}, 64'(scale_out), 64'(4096 * k));
        end
        check({tag, ".done"}, 64'(done), 64'(1));
        check({tag, ".busy_done"}, 64'(busy), 64'(1));
        tick();
        check({tag, ".done_clr"}, 64'(done), 64'(0));
        check({tag, ".busy_clr"}, 64'(busy), 64'(0));
        check({tag, ".idle_freq"}, 64'(freq_out), 64'(343596));
        check({tag, ".busy_cycles"}, 64'(busy_total - b0), 64'(21));
        check({tag, ".done_pulses"}, 64'(done_total - d0), 64'(1));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst.freq", 64'(freq_out), 64'(0));
        check("rst.scale", 64'(scale_out), 64'(0));
        check("rst.phase", 64'(phase_out), 64'(0));
        check("rst.idx", 64'(step_idx), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        rst = 1'b1;
        tick();

        // Nominal sweep
        run_nominal("nom");

        // Envelope saturation with a non-multiple target
        set_cfg(1000, 0, 1, 1, 10000, 4096, 13'h001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); check("sat.up1", 64'(scale_out), 64'(4096));
        tick(); check("sat.up2", 64'(scale_out), 64'(8192));
        tick(); check("sat.up3", 64'(scale_out), 64'(10000));
        tick(); check("sat.sweep", 64'(scale_out), 64'(10000));
        tick(); check("sat.dn1", 64'(scale_out), 64'(5904));
        tick(); check("sat.dn2", 64'(scale_out), 64'(1808));
        tick(); check("sat.dn3", 64'(scale_out), 64'(0));
        check("sat.done", 64'(done), 64'(1));
        tick();

        // Frequency wrap past 2^32
        set_cfg(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 16384, 0, 13'h010);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wrap.f0", 64'(freq_out), 64'(32'hFFFF_FF00));
        tick(); check("wrap.jump", 64'(scale_out), 64'(16384));
        tick(); check("wrap.f1", 64'(freq_out), 64'(32'h0000_0100));
        check("wrap.idx1", 64'(step_idx), 64'(1));
        tick(); check("wrap.hold", 64'(freq_out), 64'(32'h0000_0100));
        tick(); check("wrap.drop", 64'(scale_out), 64'(0));
        check("wrap.done", 64'(done), 64'(1));
        tick();

        // Negative frequency step
        set_cfg(4096, 32'hFFFF_FC00, 3, 1, 16384, 0, 13'h010);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("neg.f0", 64'(freq_out), 64'(4096));
        tick();
        tick(); check("neg.f1", 64'(freq_out), 64'(3072));
        tick(); check("neg.f2", 64'(freq_out), 64'(2048));
        tick(); check("neg.hold", 64'(freq_out), 64'(2048));
        tick(); check("neg.done", 64'(done), 64'(1));
        tick();

        // Ignored start while busy, then abort during step 1
        set_cfg(85899, 85899, 4, 3, 16384, 4096, 13'h0A5);
        d0 = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        cfg_f_start = 999;
        cfg_phase = 13'h1FF;
        tick();
        start = 1'b0;
        check("ign.scale", 64'(scale_out), 64'(8192));
        check("ign.freq", 64'(freq_out), 64'(85899));
        check("ign.phase", 64'(phase_out), 64'(13'h0A5));
        check("ign.idx", 64'(step_idx), 64'(0));
        tick();
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("abt.pre_freq", 64'(freq_out), 64'(171798));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt.freq", 64'(freq_out), 64'(171798));
        check("abt.idx", 64'(step_idx), 64'(1));
        check("abt.scale", 64'(scale_out), 64'(16384));
        for (int k = 3; k >= 0; k--) begin
            tick();
            check("abt.ramp_down", 64'(scale_out), 64'(4096 * k));
            check("abt.freq_frozen", 64'(freq_out), 64'(171798));
        end
        check("abt.done", 64'(done), 64'(1));
        tick();
        check("abt.busy_clr", 64'(busy), 64'(0));
        check("abt.done_pulses", 64'(done_total - d0), 64'(1));

        // Abort alone in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort.busy", 64'(busy), 64'(0));

        // Zero-config corner, started together with abort
        set_cfg(500, 7, 0, 0, 8192, 0, 13'h002);
        b0 = busy_total;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("zero.busy", 64'(busy), 64'(1));
        tick(); check("zero.jump", 64'(scale_out), 64'(8192));
        tick(); check("zero.step", 64'(freq_out), 64'(500));
        tick(); check("zero.drop", 64'(scale_out), 64'(0));
        check("zero.done", 64'(done), 64'(1));
        tick();
        check("zero.busy_cycles", 64'(busy_total - b0), 64'(4));

        // Reset in the middle of the sweep
        set_cfg(85899, 85899, 4, 3, 16384, 4096, 13'h0A5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        d0 = done_total;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst.freq", 64'(freq_out), 64'(0));
        check("mid_rst.scale", 64'(scale_out), 64'(0));
        check("mid_rst.phase", 64'(phase_out), 64'(0));
        check("mid_rst.idx", 64'(step_idx), 64'(0));
        check("mid_rst.busy", 64'(busy), 64'(0));
        check("mid_rst.done", 64'(done), 64'(0));
        tick();
        tick();
        check("mid_rst.still_idle", 64'(busy), 64'(0));
        check("mid_rst.no_done", 64'(done_total - d0), 64'(0));
        run_nominal("rerun");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
